// File: rtl/readout_pkg.sv
// Shared types and default sizing for the pixel readout block.
package readout_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam int DEF_PIXEL_COUNT = 4;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/pixel_readout.sv
// Captures pixel samples during read phases, subtracts a per-pixel dark
// offset and streams corrected beats through an output FIFO.
module pixel_readout import readout_pkg::*; #(
    parameter int pixel_count = DEF_PIXEL_COUNT,
    parameter int data_width  = DEF_DATA_WIDTH,
    parameter int fifo_depth  = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read,
    input  logic [$clog2(pixel_count)-1:0] pixel_select,
    input  logic [data_width-1:0]          pixel_data,
    input  logic                           capture_dark,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_width-1:0]          out_data,
    output logic [$clog2(pixel_count)-1:0] out_index,
    output logic                           out_last,
    output logic [7:0]                     frame_count,
    output logic                           overflow,
    output logic                           frame_error
);
    localparam int IDX_W   = $clog2(pixel_count);
    localparam int ENTRY_W = data_width + IDX_W + 1;

    state_t                state_q, state_d;
    logic                  entering, leaving, sample_dark;
    logic                  dark_mode_q;
    logic [15:0]           cnt_q;
    logic                  s1_valid_q, s1_dark_q;
    logic [IDX_W-1:0]      s1_sel_q;
    logic [data_width-1:0] s1_data_q;
    logic [data_width-1:0] dark_q [pixel_count];
    logic [data_width-1:0] dark_val, corrected;
    logic                  s1_last, push;
    logic                  fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    push_entry, pop_entry;
    logic                  frame_error_q, overflow_q;
    logic [7:0]            frame_count_q;

    always_comb begin
        state_d     = state_q;
        entering    = 1'b0;
        leaving     = 1'b0;
        sample_dark = dark_mode_q;
        case (state_q)
            IDLE: begin
                sample_dark = capture_dark;
                if (read) begin
                    state_d  = CAPTURE;
                    entering = 1'b1;
                end
            end
            CAPTURE: begin
                if (!read) begin
                    state_d = IDLE;
                    leaving = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dark_mode_q   <= 1'b0;
            cnt_q         <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (entering) begin
                dark_mode_q <= capture_dark;
                cnt_q       <= 16'd1;
            end else if (state_q == CAPTURE && read && cnt_q != '1) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (leaving && cnt_q != 16'(pixel_count)) frame_error_q <= 1'b1;
        end
    end

    // One-cycle sample register; its mode bit follows the sample down the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_dark_q  <= 1'b0;
            s1_sel_q   <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= read;
            s1_dark_q  <= sample_dark;
            if (read) begin
                s1_sel_q  <= pixel_select;
                s1_data_q <= pixel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < pixel_count; i++) dark_q[i] <= '0;
        end else if (s1_valid_q && s1_dark_q) begin
            dark_q[s1_sel_q] <= s1_data_q;
        end
    end

    assign dark_val   = dark_q[s1_sel_q];
    assign corrected  = (s1_data_q > dark_val) ? (s1_data_q - dark_val) : '0;
    assign s1_last    = (s1_sel_q == IDX_W'(pixel_count - 1));
    assign push       = s1_valid_q && !s1_dark_q;
    assign push_entry = {corrected, s1_sel_q, s1_last};

    sync_fifo #(
        .width (ENTRY_W),
        .depth (fifo_depth)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (out_ready),
        .pop_data_o  (pop_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (push && fifo_full && !out_ready) overflow_q <= 1'b1;
            if (out_valid && out_ready && out_last) frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign out_valid                       = !fifo_empty;
    assign {out_data, out_index, out_last} = pop_entry;
    assign frame_count                     = frame_count_q;
    assign overflow                        = overflow_q;
    assign frame_error                     = frame_error_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: table-driven frames with a beat scoreboard,
// plus stall, short-frame, mid-frame reset and frame-counter wrap sequences.
module tb_pixel_readout;

    logic       clk = 1'b0;
    logic       reset;
    logic       read;
    logic [1:0] pixel_select;
    logic [7:0] pixel_data;
    logic       capture_dark;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_last;
    logic [7:0] frame_count;
    logic       overflow;
    logic       frame_error;

    pixel_readout #(
        .pixel_count (4),
        .data_width  (8),
        .fifo_depth  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .pixel_select (pixel_select),
        .pixel_data   (pixel_data),
        .capture_dark (capture_dark),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .frame_count  (frame_count),
        .overflow     (overflow),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       beat;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } beat_t;

    vec_t  tbl [20];
    beat_t sb [$];
    int    passed = 0;
    int    total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got data %0d index %0d, none expected", out_data, out_index);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", 32'(out_data), 32'(e.d));
                check("beat_index", 32'(out_index), 32'(e.i));
                check("beat_last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic drive_rows(input int first, input int n, input logic dark);
        for (int k = first; k < first + n; k++) begin
            read         = 1'b1;
            capture_dark = (k == first) ? dark : 1'b0;
            pixel_select = tbl[k].sel;
            pixel_data   = tbl[k].data;
            if (tbl[k].beat) sb.push_back('{tbl[k].exp, tbl[k].sel, tbl[k].sel == 2'd3});
            tick();
        end
        read         = 1'b0;
        capture_dark = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            total++;
            $display("FAIL drain_timeout: %0d beats still expected", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        // rows 0-3 normal, 4-7 dark load, 8-11 corrected, 12-15 overflow, 16-18 short
        tbl[0]  = '{2'd0, 8'd10, 1'b1, 8'd10};
        tbl[1]  = '{2'd1, 8'd20, 1'b1, 8'd20};
        tbl[2]  = '{2'd2, 8'd30, 1'b1, 8'd30};
        tbl[3]  = '{2'd3, 8'd40, 1'b1, 8'd40};
        tbl[4]  = '{2'd0, 8'd5,  1'b0, 8'd0};
        tbl[5]  = '{2'd1, 8'd5,  1'b0, 8'd0};
        tbl[6]  = '{2'd2, 8'd50, 1'b0, 8'd0};
        tbl[7]  = '{2'd3, 8'd0,  1'b0, 8'd0};
        tbl[8]  = '{2'd0, 8'd10, 1'b1, 8'd5};
        tbl[9]  = '{2'd1, 8'd20, 1'b1, 8'd15};
        tbl[10] = '{2'd2, 8'd30, 1'b1, 8'd0};
        tbl[11] = '{2'd3, 8'd40, 1'b1, 8'd40};
        tbl[12] = '{2'd0, 8'd10, 1'b1, 8'd5};
        tbl[13] = '{2'd1, 8'd20, 1'b1, 8'd15};
        tbl[14] = '{2'd2, 8'd30, 1'b0, 8'd0};
        tbl[15] = '{2'd3, 8'd40, 1'b0, 8'd0};
        tbl[16] = '{2'd0, 8'd10, 1'b1, 8'd5};
        tbl[17] = '{2'd1, 8'd20, 1'b1, 8'd15};
        tbl[18] = '{2'd2, 8'd30, 1'b1, 8'd0};
        tbl[19] = '{2'd3, 8'd0,  1'b0, 8'd0};

        reset = 1'b1; read = 1'b0; pixel_select = '0; pixel_data = '0;
        capture_dark = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        reset = 1'b0;
        tick();

        // Normal frame, dark all zero
        drive_rows(0, 4, 1'b0);
        wait_drain();
        check("normal_frame_count", 32'(frame_count), 1);
        check("normal_frame_error", 32'(frame_error), 0);

        // Dark load: capture_dark only on the first sample, still a dark phase
        drive_rows(4, 4, 1'b1);
        tick(); tick();
        check("dark_no_beats_valid", 32'(out_valid), 0);
        check("dark_frame_count", 32'(frame_count), 1);
        drive_rows(8, 4, 1'b0);
        wait_drain();
        check("corrected_frame_count", 32'(frame_count), 2);

        // Overflow with stalled output
        out_ready = 1'b0;
        drive_rows(12, 4, 1'b0);
        tick();
        check("ovf_flag", 32'(overflow), 1);
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 5);
            check("stall_index", 32'(out_index), 0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain();
        check("ovf_drained_valid", 32'(out_valid), 0);
        check("ovf_frame_count", 32'(frame_count), 2);
        check("ovf_sticky", 32'(overflow), 1);
        check("pre_short_frame_error", 32'(frame_error), 0);

        // Short frame: 3 samples
        drive_rows(16, 3, 1'b0);
        wait_drain();
        check("short_frame_error", 32'(frame_error), 1);
        check("short_frame_count", 32'(frame_count), 2);

        // Reset after two samples; nothing queued may survive
        out_ready = 1'b0;
        read = 1'b1; pixel_select = 2'd0; pixel_data = 8'd77; tick();
        pixel_select = 2'd1; pixel_data = 8'd88; tick();
        read = 1'b0; reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_frame_count", 32'(frame_count), 0);
        check("midrst_overflow", 32'(overflow), 0);
        check("midrst_frame_error", 32'(frame_error), 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("postrst_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        drive_rows(0, 4, 1'b0);
        wait_drain();
        check("postrst_frame_count", 32'(frame_count), 1);

        // Frame counter wrap
        for (int f = 0; f < 255; f++) begin
            for (int p = 0; p < 4; p++) begin
                tbl[p].sel  = 2'(p);
                tbl[p].data = 8'($urandom_range(0, 255));
                tbl[p].beat = 1'b1;
                tbl[p].exp  = tbl[p].data;
            end
            drive_rows(0, 4, 1'b0);
            if (f == 253) begin
                wait_drain();
                check("wrap_255", 32'(frame_count), 255);
            end
        end
        wait_drain();
        check("wrap_to_zero", 32'(frame_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
